// File: rtl/sd_spi_burst_if.sv
// ---------------------------------------------------------------------------
// sd_spi_burst_if
// Bundles every non-clock signal of sd_spi_burst.
//   command : start, len, write_mode
//   tx      : tx_data, tx_valid, tx_ready   (valid/ready byte stream)
//   rx      : rx_data, rx_valid             (one-cycle pulse per byte)
//   status  : busy, done, underrun
//   spi     : spi_data_in, spi_trigger, spi_data_out, spi_data_valid, spi_cs
//             (wired straight to the byte-level SPI controller)
// slave  modport : the burst sequencer itself.
// master modport : whatever drives commands and hosts the controller.
// ---------------------------------------------------------------------------
interface sd_spi_burst_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 10
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  len;
    logic                  write_mode;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  busy;
    logic                  done;
    logic                  underrun;
    logic [DATA_WIDTH-1:0] spi_data_in;
    logic                  spi_trigger;
    logic [DATA_WIDTH-1:0] spi_data_out;
    logic                  spi_data_valid;
    logic                  spi_cs;

    modport slave (
        input  start, len, write_mode, tx_data, tx_valid,
               spi_data_out, spi_data_valid, spi_cs,
        output tx_ready, rx_data, rx_valid, busy, done, underrun,
               spi_data_in, spi_trigger
    );

    modport master (
        output start, len, write_mode, tx_data, tx_valid,
               spi_data_out, spi_data_valid, spi_cs,
        input  tx_ready, rx_data, rx_valid, busy, done, underrun,
               spi_data_in, spi_trigger
    );
endinterface

// File: rtl/sd_spi_burst.sv
// ---------------------------------------------------------------------------
// sd_spi_burst
// Multi-byte burst sequencer in front of a continuous-CS SPI byte controller.
// One start command moves len bytes back-to-back in one chip-select window:
// write mode pulls bytes from the TX stream, read mode sends FILL_BYTE.
// Every received byte is forwarded as a one-cycle rx_valid pulse and the
// burst closes with a one-cycle done pulse.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (shared with the SPI controller)
//   bus  - sd_spi_burst_if.slave (command, TX/RX streams, status, SPI side)
// ---------------------------------------------------------------------------
module sd_spi_burst #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    LEN_WIDTH  = 10,
    parameter logic [DATA_WIDTH-1:0] FILL_BYTE  = 8'hFF
) (
    input  logic         clk,
    input  logic         rst,
    sd_spi_burst_if.slave bus
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                state_reg, state_next;

    logic [LEN_WIDTH-1:0]  len_reg;
    logic                  write_mode_reg;
    logic [DATA_WIDTH-1:0] nxt_reg;
    logic                  nxt_full_reg;
    logic [LEN_WIDTH-1:0]  fetch_cnt_reg;
    logic [LEN_WIDTH-1:0]  sent_cnt_reg;
    logic [LEN_WIDTH-1:0]  rx_cnt_reg;
    logic                  trig_q_reg;
    logic [DATA_WIDTH-1:0] rx_data_reg;
    logic                  rx_valid_reg;
    logic                  underrun_reg;
    logic                  done_reg;

    logic                  start_ok;
    logic                  in_run;
    logic                  fetch_ok;
    logic                  tx_ready;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_byte;
    logic                  trigger;
    logic                  consume;
    logic                  rx_accept;
    logic                  rx_last;
    logic                  under_hit;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.len == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (rx_last) begin
                    state_next = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / control decode, all from registered state plus live inputs
    always_comb begin
        start_ok  = (state_reg == IDLE) && bus.start;
        in_run    = (state_reg == RUN);
        fetch_ok  = in_run && !nxt_full_reg && (fetch_cnt_reg < len_reg);
        tx_ready  = fetch_ok && write_mode_reg;
        load      = fetch_ok && (!write_mode_reg || bus.tx_valid);
        load_byte = write_mode_reg ? bus.tx_data : FILL_BYTE;
        trigger   = in_run && nxt_full_reg && (sent_cnt_reg < len_reg);
        // The controller takes data_in either when it is idle (cs high) or at
        // a byte boundary if it saw trigger on the previous cycle.
        consume   = in_run && ((trigger && bus.spi_cs) ||
                               (bus.spi_data_valid && trig_q_reg));
        rx_accept = in_run && bus.spi_data_valid;
        // rx_cnt < len in RUN, so the +1 never wraps.
        rx_last   = rx_accept && ((rx_cnt_reg + LEN_ONE) == len_reg);
        // A byte boundary with no pending trigger makes the controller drop CS.
        under_hit = rx_accept && !trig_q_reg && ((rx_cnt_reg + LEN_ONE) < len_reg);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            len_reg        <= '0;
            write_mode_reg <= 1'b0;
            nxt_reg        <= '0;
            nxt_full_reg   <= 1'b0;
            fetch_cnt_reg  <= '0;
            sent_cnt_reg   <= '0;
            rx_cnt_reg     <= '0;
            trig_q_reg     <= 1'b0;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            underrun_reg   <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            trig_q_reg   <= trigger;
            rx_valid_reg <= rx_accept;
            underrun_reg <= under_hit;
            done_reg     <= (state_reg == FINISH);
            if (rx_accept) begin
                rx_data_reg <= bus.spi_data_out;
            end

            if (start_ok) begin
                len_reg        <= bus.len;
                write_mode_reg <= bus.write_mode;
                nxt_full_reg   <= 1'b0;
                fetch_cnt_reg  <= '0;
                sent_cnt_reg   <= '0;
                rx_cnt_reg     <= '0;
            end else begin
                // load needs !nxt_full and consume implies nxt_full, so the
                // two never coincide.
                if (load) begin
                    nxt_reg       <= load_byte;
                    nxt_full_reg  <= 1'b1;
                    fetch_cnt_reg <= fetch_cnt_reg + LEN_ONE;
                end else if (consume) begin
                    nxt_full_reg  <= 1'b0;
                    sent_cnt_reg  <= sent_cnt_reg + LEN_ONE;
                end
                if (rx_accept) begin
                    rx_cnt_reg <= rx_cnt_reg + LEN_ONE;
                end
            end
        end
    end

    assign bus.tx_ready    = tx_ready;
    assign bus.rx_data     = rx_data_reg;
    assign bus.rx_valid    = rx_valid_reg;
    assign bus.busy        = (state_reg != IDLE) || done_reg;
    assign bus.done        = done_reg;
    assign bus.underrun    = underrun_reg;
    assign bus.spi_data_in = nxt_reg;
    assign bus.spi_trigger = trigger;

endmodule
